// File: rtl/ltssm_detect_ctrl.sv
// LTSSM Detect-state sequencer: times Detect.Quiet / Detect.Active, issues the
// receiver-detect request to the PIPE control stage and hands off to Polling.
module ltssm_detect_ctrl #(
  parameter int QUIET_CYCLES  = 12000,
  parameter int ACTIVE_CYCLES = 64,
  parameter int CNT_W         = 16
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       link_down,
  input  logic       rx_elec_idle,
  input  logic       detect_status,
  output logic       elecidle_req,
  output logic       detect_req,
  output logic       detect_done,
  output logic [7:0] fail_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUIET  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] QUIET_LAST  = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(ACTIVE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       fail_q, fail_d;
  logic             rx_prev_q;
  logic             elecidle_q, elecidle_d;
  logic             detect_req_q, detect_req_d;
  logic             detect_done_q, detect_done_d;
  logic             rx_fall;

  // The edge is only trusted once rx_prev_q was captured inside QUIET (timer != 0).
  assign rx_fall = (timer_q != '0) && rx_prev_q && !rx_elec_idle;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      fail_q        <= '0;
      rx_prev_q     <= 1'b0;
      elecidle_q    <= 1'b1;
      detect_req_q  <= 1'b0;
      detect_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      fail_q        <= fail_d;
      rx_prev_q     <= rx_elec_idle;
      elecidle_q    <= elecidle_d;
      detect_req_q  <= detect_req_d;
      detect_done_q <= detect_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (start) state_d = ST_QUIET;
      end
      ST_QUIET: begin
        if (timer_q == QUIET_LAST || rx_fall) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Success wins over a coincident timeout.
        if (detect_status) begin
          state_d = ST_DONE;
        end else if (timer_q == ACTIVE_LAST) begin
          state_d = ST_QUIET;
          if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
        end
      end
      default: begin
        timer_d = '0;
      end
    endcase
    if (link_down) begin
      state_d = ST_IDLE;
      fail_d  = fail_q;
    end
    if (state_d != state_q) timer_d = '0;
    detect_req_d  = (state_q == ST_QUIET)  && (state_d == ST_ACTIVE);
    detect_done_d = (state_q == ST_ACTIVE) && (state_d == ST_DONE);
    elecidle_d    = (state_d != ST_DONE);
  end

  assign elecidle_req = elecidle_q;
  assign detect_req   = detect_req_q;
  assign detect_done  = detect_done_q;
  assign fail_count   = fail_q;
  assign state        = state_q;

endmodule
